// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency synchronous memory between the core and a debug/loader port
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  state_t state, state_nx;
  logic last_owner, owner, cmd_we, core_elig, grant, grant_dbg;
  logic [LW-1:0] lat_cnt;
  // arbitration: dbg always eligible, core only when unlocked; ties go to whoever was not served last (1 = dbg)
  always_comb begin
    core_elig = core_req & ~dbg_lock;
    grant     = core_elig | dbg_req;
    grant_dbg = dbg_req & (~core_elig | ~last_owner);
  end
  // next-state sequencing and state-decoded strobes
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = grant ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = lat_cnt == '0 ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
    mem_en     = state == ISSUE;
    mem_we     = mem_en & cmd_we;
    core_ack   = state == RESP & ~owner;
    dbg_ack    = state == RESP & owner;
    busy       = state != IDLE;
    core_stall = core_req & ~core_ack;
  end
  // state, command latch at grant, latency countdown and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      lat_cnt    <= '0;
      cmd_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant) begin
        owner      <= grant_dbg;
        last_owner <= grant_dbg;
        cmd_we     <= grant_dbg ? dbg_we : core_we;
        mem_addr   <= grant_dbg ? dbg_addr : core_addr;
        mem_wdata  <= grant_dbg ? dbg_wdata : core_wdata;
      end
      if (state == ISSUE) lat_cnt <= LW'(MEM_LATENCY - 1);
      if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
      if (state == WAIT && lat_cnt == '0 && owner) dbg_rdata <= mem_rdata;
      if (state == WAIT && lat_cnt == '0 && !owner) core_rdata <= mem_rdata;
    end
  end
endmodule
